// File: rtl/logic_unit_cdb_issue_if.sv
// logic_unit_cdb_issue_if: dispatch, flush and CDB handshake bundle for the logic unit.
interface logic_unit_cdb_issue_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 2
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic              flush;
   logic              disp_valid;
   logic              disp_ready;
   logic [1:0]        disp_op;
   logic [DATA_W-1:0] disp_a;
   logic [DATA_W-1:0] disp_b;
   logic [TAG_W-1:0]  disp_tag;
   logic              cdb_req;
   logic              cdb_grant;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic [CW-1:0]     occupancy;
   modport master (
      output flush, disp_valid, disp_op, disp_a, disp_b, disp_tag, cdb_grant,
      input  disp_ready, cdb_req, cdb_tag, cdb_data, occupancy
   );
   modport slave (
      input  flush, disp_valid, disp_op, disp_a, disp_b, disp_tag, cdb_grant,
      output disp_ready, cdb_req, cdb_tag, cdb_data, occupancy
   );
endinterface

// File: rtl/logic_unit_cdb_issue.sv
// logic_unit_cdb_issue: bitwise logic unit buffering results in a FIFO and retiring one per CDB grant.
module logic_unit_cdb_issue #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 2
) (
   input logic                  clk,
   input logic                  reset,
   logic_unit_cdb_issue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              push, pop;
   logic [DATA_W-1:0] res;
   assign bus.disp_ready = cnt_q != CW'(DEPTH);
   assign bus.cdb_req    = cnt_q != '0;
   assign bus.cdb_tag    = bus.cdb_req ? tag_q[rd_q] : '0;
   assign bus.cdb_data   = bus.cdb_req ? data_q[rd_q] : '0;
   assign bus.occupancy  = cnt_q;
   always_comb begin
      push  = bus.disp_valid & bus.disp_ready;
      pop   = bus.cdb_req & bus.cdb_grant;
      res   = bus.disp_op == 2'b00 ? bus.disp_a & bus.disp_b :
              bus.disp_op == 2'b01 ? bus.disp_a | bus.disp_b :
              bus.disp_op == 2'b10 ? bus.disp_a ^ bus.disp_b :
                                     ~(bus.disp_a ^ bus.disp_b);
      cnt_d = bus.flush ? '0 : cnt_q + CW'(push) - CW'(pop);
      rd_d  = bus.flush ? '0 : rd_q + PW'(pop);
      wr_d  = bus.flush ? '0 : wr_q + PW'(push);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
      end
   end
   // Storage needs no reset: outputs are masked to zero whenever the count is zero.
   always_ff @(posedge clk) begin
      if (push && !bus.flush && !reset) begin
         tag_q[wr_q]  <= bus.disp_tag;
         data_q[wr_q] <= res;
      end
   end
endmodule

// File: tb/tb_logic_unit_cdb_issue.sv
// tb_logic_unit_cdb_issue: directed and randomized checks of the logic unit against a queue model.
module tb_logic_unit_cdb_issue;
   localparam int DEPTH = 2;
   logic clk = 0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [35:0] q[$];
   always #5 clk = ~clk;
   logic_unit_cdb_issue_if #(.DATA_W(32), .TAG_W(4), .DEPTH(DEPTH)) bus ();
   logic_unit_cdb_issue #(.DATA_W(32), .TAG_W(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         int n;
         n = int'(a[i]) + int'(b[i]);
         case (op)
            2'd0: r[i] = (n == 2);
            2'd1: r[i] = (n >= 1);
            2'd2: r[i] = (n == 1);
            default: r[i] = (n != 1);
         endcase
      end
      return r;
   endfunction
   function automatic logic [3:0] exp_tag();
      return q.size() != 0 ? q[0][35:32] : 4'd0;
   endfunction
   function automatic logic [31:0] exp_data();
      return q.size() != 0 ? q[0][31:0] : 32'd0;
   endfunction
   task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic g, input logic f, input logic r);
      logic do_push, do_pop;
      bus.disp_valid = v; bus.disp_op = op; bus.disp_a = a; bus.disp_b = b;
      bus.disp_tag = tag; bus.cdb_grant = g; bus.flush = f; reset = r;
      do_pop  = q.size() != 0 && g;
      do_push = v && q.size() != DEPTH;
      @(posedge clk);
      if (r || f) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({tag, model_op(op, a, b)});
      end
      #1;
   endtask
   task automatic idle(input logic g);
      step(0, 2'd0, 32'd0, 32'd0, 4'd0, g, 0, 0);
   endtask
   task automatic test_reset();
      step(0, 2'd0, 32'd0, 32'd0, 4'd0, 0, 0, 1);
      step(0, 2'd0, 32'd0, 32'd0, 4'd0, 0, 0, 1);
      checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.cdb_req); end
      checks++; if (bus.cdb_data !== 32'd0 || bus.cdb_tag !== 4'd0) begin errors++; $display("FAIL reset_out got %h/%h exp 0/0", bus.cdb_tag, bus.cdb_data); end
      checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", bus.occupancy); end
      checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.disp_ready); end
   endtask
   task automatic test_single();
      step(1, 2'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd3, 1, 0, 0);
      checks++; if (bus.cdb_req !== 1'b1 || bus.cdb_tag !== 4'd3 || bus.cdb_data !== 32'hF0F0_0F0F)
         begin errors++; $display("FAIL single_out got %b/%h/%h exp 1/3/f0f00f0f", bus.cdb_req, bus.cdb_tag, bus.cdb_data); end
      idle(1);
      checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", bus.cdb_req); end
   endtask
   task automatic test_backpressure();
      logic [31:0] a1, b1, a2, b2;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      step(1, 2'd0, a1, b1, 4'd1, 0, 0, 0);
      step(1, 2'd1, a2, b2, 4'd2, 0, 0, 0);
      checks++; if (bus.occupancy !== 2'd2 || bus.disp_ready !== 1'b0)
         begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", bus.occupancy, bus.disp_ready); end
      for (int i = 0; i < 2; i++) begin
         step(1, 2'd3, 32'd5, 32'd6, 4'd7, 0, 0, 0);
         checks++; if (bus.cdb_tag !== 4'd1 || bus.cdb_data !== (a1 & b1) || bus.occupancy !== 2'd2)
            begin errors++; $display("FAIL bp_stall got %h/%h occ=%0d exp 1/%h occ=2", bus.cdb_tag, bus.cdb_data, bus.occupancy, a1 & b1); end
      end
      step(1, 2'd3, 32'd5, 32'd6, 4'd7, 1, 0, 0);
      checks++; if (bus.cdb_tag !== 4'd2 || bus.cdb_data !== (a2 | b2) || bus.occupancy !== 2'd1)
         begin errors++; $display("FAIL bp_order got %h/%h occ=%0d exp 2/%h occ=1", bus.cdb_tag, bus.cdb_data, bus.occupancy, a2 | b2); end
      step(1, 2'd3, 32'd5, 32'd6, 4'd7, 1, 0, 0);
      checks++; if (bus.cdb_tag !== 4'd7 || bus.cdb_data !== 32'hFFFF_FFFC || bus.occupancy !== 2'd1)
         begin errors++; $display("FAIL bp_held got %h/%h occ=%0d exp 7/fffffffc occ=1", bus.cdb_tag, bus.cdb_data, bus.occupancy); end
      idle(1);
      checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus.cdb_req); end
   endtask
   task automatic test_push_pop();
      step(1, 2'd1, 32'h1, 32'h2, 4'd4, 0, 0, 0);
      step(1, 2'd3, 32'd0, 32'd0, 4'd5, 1, 0, 0);
      checks++; if (bus.occupancy !== 2'd1 || bus.cdb_tag !== 4'd5 || bus.cdb_data !== 32'hFFFF_FFFF)
         begin errors++; $display("FAIL pushpop got occ=%0d %h/%h exp occ=1 5/ffffffff", bus.occupancy, bus.cdb_tag, bus.cdb_data); end
      idle(1);
   endtask
   task automatic test_flush();
      step(1, 2'd0, $urandom, $urandom, 4'd8, 0, 0, 0);
      step(1, 2'd1, $urandom, $urandom, 4'd9, 0, 0, 0);
      step(1, 2'd2, $urandom, $urandom, 4'd10, 1, 1, 0);
      checks++; if (bus.occupancy !== 2'd0 || bus.cdb_req !== 1'b0 || bus.cdb_tag !== 4'd0 || bus.cdb_data !== 32'd0)
         begin errors++; $display("FAIL flush got occ=%0d req=%b %h/%h exp all 0", bus.occupancy, bus.cdb_req, bus.cdb_tag, bus.cdb_data); end
      idle(0);
      checks++; if (bus.cdb_req !== 1'b0 || bus.disp_ready !== 1'b1)
         begin errors++; $display("FAIL flush_after got req=%b rdy=%b exp 0/1", bus.cdb_req, bus.disp_ready); end
   endtask
   task automatic test_spurious_and_reset();
      idle(1);
      idle(1);
      checks++; if (bus.occupancy !== 2'd0 || bus.cdb_req !== 1'b0)
         begin errors++; $display("FAIL spurious got occ=%0d req=%b exp 0/0", bus.occupancy, bus.cdb_req); end
      step(1, 2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd11, 0, 0, 0);
      step(1, 2'd1, 32'h0000_000F, 32'h0000_00F0, 4'd12, 0, 0, 0);
      checks++; if (bus.cdb_tag !== 4'd11 || bus.cdb_data !== 32'hF000_F000)
         begin errors++; $display("FAIL spurious_ptr got %h/%h exp b/f000f000", bus.cdb_tag, bus.cdb_data); end
      step(1, 2'd2, 32'h1, 32'h3, 4'd13, 1, 0, 1);
      checks++; if (bus.occupancy !== 2'd0 || bus.cdb_req !== 1'b0 || bus.cdb_tag !== 4'd0 || bus.cdb_data !== 32'd0 || bus.disp_ready !== 1'b1)
         begin errors++; $display("FAIL midreset got occ=%0d req=%b %h/%h rdy=%b exp 0 0 0/0 1", bus.occupancy, bus.cdb_req, bus.cdb_tag, bus.cdb_data, bus.disp_ready); end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom, 4'($urandom),
              1'($urandom_range(0, 2) == 0), $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
         checks++;
         if (bus.occupancy !== 2'(q.size()) || bus.cdb_req !== (q.size() != 0) || bus.disp_ready !== (q.size() != DEPTH) ||
             bus.cdb_tag !== exp_tag() || bus.cdb_data !== exp_data()) begin
            errors++;
            $display("FAIL random[%0d] got occ=%0d req=%b rdy=%b %h/%h exp occ=%0d %h/%h", i, bus.occupancy, bus.cdb_req,
                     bus.disp_ready, bus.cdb_tag, bus.cdb_data, q.size(), exp_tag(), exp_data());
         end
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_push_pop();
      test_flush();
      test_spurious_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
